icache_direct_mapped: RTL

- Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory.
- Serves 32-bit instructions to the CPU on a hit in the same cycle.
- On a miss, stalls the CPU with busywait, fetches the whole 128-bit block over the memory's read/busywait handshake, installs it, then serves the instruction.
- Holds saturating hit and miss counters for performance measurement.

---
 rtl/icache_direct_mapped_if.sv | 39 +++
 rtl/icache_direct_mapped.sv | 121 ++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped_if.sv
// Bus bundle between the instruction cache and its two neighbours: the CPU
// fetch stage (cpu_read/pc in, instruction/busywait out) and the block
// instruction memory (mem_read/mem_address out, mem_readinst/mem_busywait in).
//
// Handshakes:
//   CPU side  - the CPU holds cpu_read and pc stable while busywait=1; an
//               instruction is delivered in any cycle with cpu_read=1 and
//               busywait=0, and it is consumed on that cycle's posedge.
//   Mem side  - the cache raises mem_read with a stable mem_address; memory
//               raises mem_busywait and drops it once mem_readinst holds the
//               block; the cache captures the block on the next posedge and
//               drops mem_read.
interface icache_direct_mapped_if #(
  parameter int CNT_BITS = 16
);
  logic                cpu_read;
  logic [31:0]         pc;
  logic [31:0]         instruction;
  logic                busywait;
  logic                mem_read;
  logic [5:0]          mem_address;
  logic [127:0]        mem_readinst;
  logic                mem_busywait;
  logic [CNT_BITS-1:0] hit_count;
  logic [CNT_BITS-1:0] miss_count;
  logic [1:0]          debug_state;

  modport slave (
    input  cpu_read, pc, mem_readinst, mem_busywait,
    output instruction, busywait, mem_read, mem_address,
           hit_count, miss_count, debug_state
  );

  modport master (
    output cpu_read, pc, mem_readinst, mem_busywait,
    input  instruction, busywait, mem_read, mem_address,
           hit_count, miss_count, debug_state
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with 16-byte blocks. Hits are
// served combinationally; misses stall the CPU, fetch the whole block from
// memory, install it, and then serve the request as a hit.
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  icache_direct_mapped_if.slave bus
);
  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0]            state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_BITS-1:0]   tag_array  [NUM_BLOCKS];
  logic [127:0]          data_array [NUM_BLOCKS];
  logic [5:0]            miss_addr;
  logic [127:0]          fill_data;
  logic                  first_cycle;
  logic                  mem_read_q;
  logic [5:0]            mem_address_q;
  logic [CNT_BITS-1:0]   hit_count;
  logic [CNT_BITS-1:0]   miss_count;

  logic [1:0]            word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  fill_done;
  logic [INDEX_BITS-1:0] fill_index;
  logic                  unused_pc_bits;

  assign word_sel       = bus.pc[3:2];
  assign index          = bus.pc[3+INDEX_BITS:4];
  assign tag            = bus.pc[9:4+INDEX_BITS];
  assign unused_pc_bits = ^{bus.pc[31:10], bus.pc[1:0]};

  // Fill bookkeeping always uses the latched miss address, never the live pc.
  assign fill_index = miss_addr[INDEX_BITS-1:0];
  // Memory response is accepted only once the request has been up a full cycle.
  assign fill_done  = (state == MEM_READ) && !first_cycle && !bus.mem_busywait;

  assign hit = (state == IDLE) && !reset && bus.cpu_read && valid[index] &&
               (tag_array[index] == tag);

  // CPU-facing outputs: same-cycle hit data and stall.
  always_comb begin
    bus.instruction = 32'h0;
    bus.busywait    = 1'b0;
    if (hit) begin
      bus.instruction = data_array[index][{word_sel, 5'b0} +: 32];
    end
    if (!reset) begin
      bus.busywait = (state == IDLE) ? (bus.cpu_read && !hit) : 1'b1;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;
  assign bus.hit_count   = hit_count;
  assign bus.miss_count  = miss_count;
  assign bus.debug_state = state;

  // Control FSM, valid bits, memory request and saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= 6'd0;
      miss_addr     <= 6'd0;
      first_cycle   <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else if (bus.cpu_read) begin
            miss_addr     <= {tag, index};
            mem_address_q <= {tag, index};
            mem_read_q    <= 1'b1;
            first_cycle   <= 1'b1;
            state         <= MEM_READ;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
        MEM_READ: begin
          first_cycle <= 1'b0;
          if (fill_done) begin
            mem_read_q <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          valid[fill_index] <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block storage: capture the memory block, then install it with its tag.
  always_ff @(posedge clock) begin
    if (fill_done) begin
      fill_data <= bus.mem_readinst;
    end
    if (state == UPDATE) begin
      data_array[fill_index] <= fill_data;
      tag_array[fill_index]  <= miss_addr[5:INDEX_BITS];
    end
  end
endmodule
